// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one imem request per STATE_IF visit and registers the word for decode.
// Optional misaligned-PC trap enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter logic [2:0]        STATE_IF = 3'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_done,
    output logic              fetch_err
);

    // state  | meaning
    // F_IDLE | waiting for the control FSM to enter STATE_IF
    // F_WAIT | request outstanding, address held until imem_ack
    // F_DONE | word captured; parked here until STATE_IF is left
    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_DONE
    } f_state_t;

    f_state_t          f_state, f_next;
    logic [ADDR_W-1:0] pc_next, pc_plus4_next, imem_addr_next;
    logic [31:0]       instruction_next;
    logic              imem_req_next, fetch_done_next;
    logic              in_if, issue_ok;

    assign in_if = (state == STATE_IF);

`ifdef FETCH_ALIGN_CHK_EN
    logic fetch_err_q, fetch_err_next;
    assign issue_ok  = (pc[1:0] == 2'b00);
    assign fetch_err = fetch_err_q;
`else
    assign issue_ok  = 1'b1;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state     <= F_IDLE;
            pc          <= PC_RESET;
            pc_plus4    <= PC_RESET + ADDR_W'(4);
            imem_addr   <= PC_RESET;
            imem_req    <= 1'b0;
            instruction <= 32'h0;
            fetch_done  <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            f_state     <= f_next;
            pc          <= pc_next;
            pc_plus4    <= pc_plus4_next;
            imem_addr   <= imem_addr_next;
            imem_req    <= imem_req_next;
            instruction <= instruction_next;
            fetch_done  <= fetch_done_next;
`ifdef FETCH_ALIGN_CHK_EN
            fetch_err_q <= fetch_err_next;
`endif
        end
    end

    always_comb begin
        f_next           = f_state;
        pc_next          = pc;
        pc_plus4_next    = pc_plus4;
        imem_addr_next   = imem_addr;
        imem_req_next    = imem_req;
        instruction_next = instruction;
        fetch_done_next  = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        fetch_err_next   = fetch_err_q;
`endif

        unique case (f_state)
            F_IDLE: begin
                // imem_ack is deliberately ignored here: it can only be stale
                if (in_if) begin
                    if (issue_ok) begin
                        imem_req_next  = 1'b1;
                        imem_addr_next = pc;
                        f_next         = F_WAIT;
`ifdef FETCH_ALIGN_CHK_EN
                        fetch_err_next = 1'b0;
`endif
                    end else begin
                        instruction_next = 32'h0;
                        fetch_done_next  = 1'b1;
                        f_next           = F_DONE;
`ifdef FETCH_ALIGN_CHK_EN
                        fetch_err_next   = 1'b1;
`endif
                    end
                end
            end
            F_WAIT: begin
                if (imem_ack) begin
                    instruction_next = imem_rdata;
                    pc_plus4_next    = imem_addr + ADDR_W'(4);
                    pc_next          = imem_addr + ADDR_W'(4);
                    imem_req_next    = 1'b0;
                    fetch_done_next  = 1'b1;
                    // a transaction that outlived its IF visit must not park in F_DONE
                    f_next           = in_if ? F_DONE : F_IDLE;
                end
            end
            F_DONE: begin
                if (!in_if) f_next = F_IDLE;
            end
            default: f_next = F_IDLE;
        endcase

        // redirects win over the sequential increment, including on the ack edge
        if (pc_load) pc_next = pc_load_val;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, and a randomized
// run against a transaction-level PC/instruction model.
module tb_fetch_unit;

    localparam logic [2:0] ST_IF = 3'd1;
    localparam logic [2:0] ST_ID = 3'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        fetch_err;

    int passed = 0;
    int total  = 0;
    logic [31:0] pc_m;

    fetch_unit #(.ADDR_W(32), .PC_RESET(32'h0), .STATE_IF(ST_IF)) dut (
        .clk(clk), .rst_n(rst_n), .state(state),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_load(pc_load), .pc_load_val(pc_load_val),
        .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_done(fetch_done), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned delay;
        logic [31:0] rdata;
        logic        ld_ack;
        logic        ld_mid;
        logic [31:0] ld_val;
        int unsigned stay;
        logic        leave;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pp4;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One complete IF visit; ld_mid and leave act in the first wait cycle and need delay >= 1.
    task automatic run_fetch(input int unsigned delay, input logic [31:0] rdata,
                             input logic ld_ack, input logic ld_mid, input logic [31:0] ld_val,
                             input int unsigned stay, input logic leave,
                             input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                             input logic [31:0] exp_pp4);
        state = ST_IF;
        tick();
        chk("req_issued", {31'b0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        chk("err_clear", {31'b0, fetch_err}, 32'd0);
        for (int k = 0; k < int'(delay); k++) begin
            if (k == 0 && ld_mid) begin
                pc_load = 1'b1;
                pc_load_val = ld_val;
            end
            if (k == 0 && leave) state = ST_ID;
            tick();
            pc_load = 1'b0;
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, exp_addr);
            chk("no_early_done", {31'b0, fetch_done}, 32'd0);
            if (k == 0 && ld_mid) chk("mid_load_pc", pc, ld_val);
        end
        imem_ack = 1'b1;
        imem_rdata = rdata;
        if (ld_ack) begin
            pc_load = 1'b1;
            pc_load_val = ld_val;
        end
        tick();
        imem_ack = 1'b0;
        pc_load = 1'b0;
        chk("done_pulse", {31'b0, fetch_done}, 32'd1);
        chk("instruction", instruction, rdata);
        chk("pc_after", pc, exp_pc);
        chk("pc_plus4", pc_plus4, exp_pp4);
        chk("req_dropped", {31'b0, imem_req}, 32'd0);
        if (!leave) begin
            for (int s = 0; s < int'(stay); s++) begin
                tick();
                chk("no_refetch", {31'b0, imem_req}, 32'd0);
                chk("done_single", {31'b0, fetch_done}, 32'd0);
            end
            state = ST_ID;
        end
        tick();
        chk("done_low_after", {31'b0, fetch_done}, 32'd0);
        chk("idle_no_req", {31'b0, imem_req}, 32'd0);
        pc_m = exp_pc;
    endtask

    task automatic load_pc(input logic [31:0] val);
        pc_load = 1'b1;
        pc_load_val = val;
        tick();
        pc_load = 1'b0;
        chk("load_pc", pc, val);
        pc_m = val;
    endtask

    initial begin
        tbl[0] = '{0, 32'h8C22_0004, 1'b0, 1'b0, 32'h0,   1,  1'b0, 32'h00, 32'h04, 32'h04};
        tbl[1] = '{5, 32'h1111_1111, 1'b0, 1'b0, 32'h0,   10, 1'b0, 32'h04, 32'h08, 32'h08};
        tbl[2] = '{0, 32'h2222_2222, 1'b1, 1'b0, 32'h40,  2,  1'b0, 32'h08, 32'h40, 32'h0C};
        tbl[3] = '{2, 32'h3333_3333, 1'b0, 1'b0, 32'h0,   0,  1'b0, 32'h40, 32'h44, 32'h44};
        tbl[4] = '{3, 32'h4444_4444, 1'b0, 1'b0, 32'h0,   0,  1'b1, 32'h44, 32'h48, 32'h48};
        tbl[5] = '{2, 32'h5555_5555, 1'b0, 1'b1, 32'h100, 1,  1'b0, 32'h48, 32'h4C, 32'h4C};

        rst_n = 1'b0;
        state = ST_ID;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        pc_load = 1'b0;
        pc_load_val = 32'h0;
        pc_m = 32'h0;
        repeat (3) tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_done", {31'b0, fetch_done}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_fetch(tbl[i].delay, tbl[i].rdata, tbl[i].ld_ack, tbl[i].ld_mid, tbl[i].ld_val,
                      tbl[i].stay, tbl[i].leave, tbl[i].exp_addr, tbl[i].exp_pc, tbl[i].exp_pp4);

        // PC wraps modulo 2^32
        load_pc(32'hFFFF_FFFC);
        run_fetch(1, 32'h6666_6666, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);

        // misaligned redirect
        load_pc(32'h0000_0042);
`ifdef FETCH_ALIGN_CHK_EN
        state = ST_IF;
        tick();
        chk("align_no_req", {31'b0, imem_req}, 32'd0);
        chk("align_err", {31'b0, fetch_err}, 32'd1);
        chk("align_done", {31'b0, fetch_done}, 32'd1);
        chk("align_instr", instruction, 32'h0);
        tick();
        chk("align_done_once", {31'b0, fetch_done}, 32'd0);
        chk("align_still_no_req", {31'b0, imem_req}, 32'd0);
        state = ST_ID;
        tick();
        load_pc(32'h80);
        run_fetch(0, 32'h7777_7777, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h80, 32'h84, 32'h84);
`else
        run_fetch(0, 32'h7777_7777, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h42, 32'h46, 32'h46);
        chk("no_align_err", {31'b0, fetch_err}, 32'd0);
`endif

        // reset in the middle of an outstanding request, then a stale ack
        state = ST_IF;
        tick();
        chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        #2;
        chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_instr", instruction, 32'h0);
        state = ST_ID;
        #1;
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("stale_instr", instruction, 32'h0);
        chk("stale_done", {31'b0, fetch_done}, 32'd0);
        chk("stale_req", {31'b0, imem_req}, 32'd0);
        chk("stale_pc", pc, 32'h0);
        pc_m = 32'h0;

        for (int n = 0; n < 40; n++) begin
            int unsigned d, sel, st;
            logic lv;
            logic [31:0] rd, val, e_addr, e_pc;
            d   = $urandom_range(0, 4);
            sel = $urandom_range(0, 2);
            st  = $urandom_range(0, 3);
            rd  = $urandom;
            val = $urandom;
            val = val & 32'hFFFF_FFFC;
            if (d == 0 && sel == 2) sel = 0;
            lv = (d > 0) && ($urandom_range(0, 1) == 1);
            e_addr = pc_m;
            e_pc = (sel == 1) ? val : e_addr + 32'd4;
            run_fetch(d, rd, sel == 1, sel == 2, val, st, lv, e_addr, e_pc, e_addr + 32'd4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
